prty_chk: RTL and testbench
===========================

PRTY_CHK -- requirements
Module: prty_chk

Interface
REQ-001 SHALL have parameter DATA_WTH, default 279, payload width in bits.
REQ-002 SHALL have parameter CELL_WTH, default 32, bits covered by one parity bit.
REQ-003 SHALL have parameter CNT_WTH, default 16, error-counter width.
REQ-004 SHALL derive PRTY_WTH = ceil(DATA_WTH/CELL_WTH), not user-overridable.
REQ-005 SHALL have port clk_sys  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port data_in_vld  input  1  data_in qualifier.
REQ-008 SHALL have port data_in  input  DATA_WTH+PRTY_WTH  {parity, payload}, parity in MSBs.
REQ-009 SHALL have port err_clr  input  1  clears sticky flag, error count and first-error capture.
REQ-010 SHALL have port data_out_vld  output  1  data_out qualifier.
REQ-011 SHALL have port data_out  output  DATA_WTH  payload with parity stripped.
REQ-012 SHALL have port prty_err  output  PRTY_WTH  per-cell error vector for the current data_out beat.
REQ-013 SHALL have port prty_err_pls  output  1  one-cycle pulse, any cell errored on the current beat.
REQ-014 SHALL have port prty_err_stky  output  1  sticky error flag.
REQ-015 SHALL have port first_err_cell  output  PRTY_WTH  prty_err vector of the first errored beat since clear.
REQ-016 SHALL have port err_cnt  output  CNT_WTH  count of errored beats.

Function
REQ-017 SHALL use even parity: cell i is in error when XOR of payload[i*CELL_WTH +: CELL_WTH] and parity bit i is 1.
REQ-018 SHALL have the last cell cover payload[DATA_WTH-1:(PRTY_WTH-1)*CELL_WTH], which is shorter when DATA_WTH is not a multiple of CELL_WTH.
REQ-019 SHALL use a two-stage pipeline:
- stage 1 registers payload, valid and per-cell check;
- stage 2 registers the outputs;
- fixed latency of 2 cycles, data_in_vld to data_out_vld.
REQ-020 SHALL accept a beat every cycle, with no backpressure and no bubbles inserted.
REQ-021 SHALL force prty_err and prty_err_pls to 0 when data_out_vld is 0; data_out holds its last value.
REQ-022 SHALL set prty_err_stky on any errored output beat; it stays set until err_clr or reset.
REQ-023 SHALL load first_err_cell only when prty_err_stky is 0 and an errored beat is output.
REQ-024 SHALL increment err_cnt by one per errored beat and saturate at all-ones, with no wrap.
REQ-025 SHALL give err_clr and an errored beat in the same cycle this result: err_cnt=1, stky=1, first_err_cell=that beat's vector (the error is not lost).
REQ-026 SHALL not affect the data path with err_clr.

Reset
REQ-027 SHALL have rst_n low asynchronously zero all registers: data_out_vld, data_out, prty_err, prty_err_pls, prty_err_stky, first_err_cell, err_cnt.
REQ-028 SHALL discard beats in flight when reset is asserted mid-stream; no data_out_vld after release until new input.

Configuration
REQ-029 SHALL provide macro PRTY_CHK_ERR_CNT_EN:
- defined: err_cnt behaves per REQ-024/025;
- undefined: err_cnt tied to 0 and no counter logic synthesized.
Other outputs are identical in both cases.

Structure
REQ-030 SHALL place the prty_wth_cal ceiling function and the default CELL_WTH constant in the shared package prty_pkg, used by both the parity generator and the checker.
REQ-031 SHALL implement the per-cell XOR check in one sub-module prty_cell_chk (parameter width, outputs 1 error bit), instantiated PRTY_WTH times by a generate loop.

Verification (DATA_WTH=279, CELL_WTH=32, PRTY_WTH=9, input width 288)
REQ-032 SHALL cover: payload 0, parity 0, vld one cycle -> data_out_vld high exactly 2 cycles later, prty_err=9'h000, pls=0, stky=0.
REQ-033 SHALL cover: correct parity with payload bit 40 flipped -> prty_err=9'h002, pls=1 for one cycle, stky=1, first_err_cell=9'h002, err_cnt=1.
REQ-034 SHALL cover: payload bit 278 flipped (short last cell, 23 bits) -> prty_err=9'h100; a following beat with bits 0 and 100 flipped -> prty_err=9'h009, first_err_cell stays 9'h100, err_cnt=2.
REQ-035 SHALL cover, with PRTY_CHK_ERR_CNT_EN defined: 65540 consecutive errored beats -> err_cnt=16'hFFFF; err_clr plus errored beat in the same cycle -> err_cnt=1.
REQ-036 SHALL cover: rst_n low while 2 beats are in flight -> all outputs 0 asynchronously; no data_out_vld after release.
REQ-037 SHALL cover: macro undefined, errored beats -> err_cnt stays 0, stky and pls unchanged from the defined case.

Source files
------------

// File: rtl/prty_pkg.sv
// Shared parity definitions: default cell width and the cell-count ceiling
// helper, used by both the parity generator and the checker.
package prty_pkg;

    localparam int unsigned CELL_WTH_DEF = 32;

    // Number of parity cells needed to cover data_wth bits.
    function automatic int unsigned prty_wth_cal(input int unsigned data_wth,
                                                 input int unsigned cell_wth);
        return (data_wth + cell_wth - 1) / cell_wth;
    endfunction

endpackage

// File: rtl/prty_chk_if.sv
// Bus bundle for prty_chk: the input beat with its parity and clear, and the
// checked output beat with error reporting. The DUT uses the slave modport.
interface prty_chk_if
    import prty_pkg::*;
#(
    parameter int unsigned DATA_WTH = 279,
    parameter int unsigned CELL_WTH = CELL_WTH_DEF,
    parameter int unsigned CNT_WTH  = 16
);

    localparam int unsigned PRTY_WTH = prty_wth_cal(DATA_WTH, CELL_WTH);

    logic                         data_in_vld;
    logic [DATA_WTH+PRTY_WTH-1:0] data_in;
    logic                         err_clr;

    logic                         data_out_vld;
    logic [DATA_WTH-1:0]          data_out;
    logic [PRTY_WTH-1:0]          prty_err;
    logic                         prty_err_pls;
    logic                         prty_err_stky;
    logic [PRTY_WTH-1:0]          first_err_cell;
    logic [CNT_WTH-1:0]           err_cnt;

    modport master (
        output data_in_vld, data_in, err_clr,
        input  data_out_vld, data_out, prty_err, prty_err_pls, prty_err_stky,
               first_err_cell, err_cnt
    );

    modport slave (
        input  data_in_vld, data_in, err_clr,
        output data_out_vld, data_out, prty_err, prty_err_pls, prty_err_stky,
               first_err_cell, err_cnt
    );

endinterface

// File: rtl/prty_cell_chk.sv
// Even-parity check of one cell: flags an error when the cell bits and its
// parity bit XOR to 1.
module prty_cell_chk #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             prty_i,
    output logic             err_o
);

    assign err_o = (^data_i) ^ prty_i;

endmodule

// File: rtl/prty_chk.sv
// Two-stage pipelined parity checker. Stage 1 registers payload, valid and
// per-cell check results; stage 2 registers every output. Error bookkeeping
// (sticky flag, first-error capture, counter) updates on the same edge that
// puts a beat on data_out, so err_clr sampled on that edge is applied before
// the landing beat's error and the error is never lost.
// Optional feature: define PRTY_CHK_ERR_CNT_EN to build the saturating error
// counter; otherwise err_cnt is tied to zero.
module prty_chk
    import prty_pkg::*;
#(
    parameter int unsigned DATA_WTH = 279,
    parameter int unsigned CELL_WTH = CELL_WTH_DEF,
    parameter int unsigned CNT_WTH  = 16
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    prty_chk_if.slave  bus
);

    localparam int unsigned PRTY_WTH = prty_wth_cal(DATA_WTH, CELL_WTH);
    // The top cell is short when DATA_WTH is not a multiple of CELL_WTH.
    localparam int unsigned LAST_WTH = DATA_WTH - (PRTY_WTH - 1) * CELL_WTH;

    logic [DATA_WTH-1:0] payload;
    logic [PRTY_WTH-1:0] prty_in;
    logic [PRTY_WTH-1:0] cell_err;

    assign payload = bus.data_in[DATA_WTH-1:0];
    assign prty_in = bus.data_in[DATA_WTH+PRTY_WTH-1:DATA_WTH];

    for (genvar i = 0; i < int'(PRTY_WTH); i++) begin : g_cell
        localparam int unsigned W = (i == int'(PRTY_WTH) - 1) ? LAST_WTH : CELL_WTH;
        prty_cell_chk #(
            .WIDTH (W)
        ) u_cell (
            .data_i (payload[i*CELL_WTH +: W]),
            .prty_i (prty_in[i]),
            .err_o  (cell_err[i])
        );
    end

    logic                s1_vld_q;
    logic [DATA_WTH-1:0] s1_data_q;
    logic [PRTY_WTH-1:0] s1_err_q;

    // Stage 1: capture the beat and its per-cell check result.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_data_q <= '0;
            s1_err_q  <= '0;
        end else begin
            s1_vld_q <= bus.data_in_vld;
            if (bus.data_in_vld) begin
                s1_data_q <= payload;
                s1_err_q  <= cell_err;
            end
        end
    end

    logic                beat_err;
    logic                out_vld_q;
    logic [DATA_WTH-1:0] data_out_q;
    logic [PRTY_WTH-1:0] prty_err_q;
    logic                pls_q;
    logic                stky_q, stky_d;
    logic [PRTY_WTH-1:0] first_q, first_d;

    assign beat_err = s1_vld_q & (|s1_err_q);

    // Sticky flag and first-error capture: clear first, then apply the landing beat.
    always_comb begin
        stky_d  = stky_q;
        first_d = first_q;
        if (bus.err_clr) begin
            stky_d  = 1'b0;
            first_d = '0;
        end
        if (beat_err) begin
            if (!stky_d) begin
                first_d = s1_err_q;
            end
            stky_d = 1'b1;
        end
    end

    // Stage 2: registered outputs; error vector and pulse are zero on idle cycles.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            data_out_q <= '0;
            prty_err_q <= '0;
            pls_q      <= 1'b0;
            stky_q     <= 1'b0;
            first_q    <= '0;
        end else begin
            out_vld_q  <= s1_vld_q;
            if (s1_vld_q) begin
                data_out_q <= s1_data_q;
            end
            prty_err_q <= s1_vld_q ? s1_err_q : '0;
            pls_q      <= beat_err;
            stky_q     <= stky_d;
            first_q    <= first_d;
        end
    end

`ifdef PRTY_CHK_ERR_CNT_EN
    logic [CNT_WTH-1:0] cnt_q, cnt_d;

    // Saturating count of errored beats; a same-edge clear keeps the new error.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.err_clr) begin
            cnt_d = '0;
        end
        if (beat_err && !(&cnt_d)) begin
            cnt_d = cnt_d + CNT_WTH'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.err_cnt = cnt_q;
`else
    assign bus.err_cnt = {CNT_WTH{1'b0}};
`endif

    assign bus.data_out_vld   = out_vld_q;
    assign bus.data_out       = data_out_q;
    assign bus.prty_err       = prty_err_q;
    assign bus.prty_err_pls   = pls_q;
    assign bus.prty_err_stky  = stky_q;
    assign bus.first_err_cell = first_q;

endmodule

// File: tb/tb_prty_chk.sv
// Self-checking bench for prty_chk: directed corner beats, randomized traffic
// and a mid-stream reset, all compared against a bit-level reference model.
module tb_prty_chk;

    localparam int unsigned DW   = 279;
    localparam int unsigned CW   = 32;
    localparam int unsigned PW   = 9;
    localparam int unsigned IW   = DW + PW;
    localparam int unsigned CNTW = 16;

    logic clk_sys = 1'b0;
    logic rst_n   = 1'b0;

    prty_chk_if #(.DATA_WTH(DW), .CELL_WTH(CW), .CNT_WTH(CNTW)) bus ();

    prty_chk #(
        .DATA_WTH (DW),
        .CELL_WTH (CW),
        .CNT_WTH  (CNTW)
    ) dut (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    // Reference model state.
    logic            p_vld;   // beat presented on the previous cycle
    logic [DW-1:0]   p_data;
    logic [PW-1:0]   p_err;
    logic            o_vld;
    logic [PW-1:0]   o_err;
    logic [DW-1:0]   m_dout;
    logic            m_stky;
    logic [PW-1:0]   m_first;
    logic [CNTW-1:0] m_cnt;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Correct even-parity vector: bit b of the payload belongs to cell b/CW.
    function automatic logic [PW-1:0] calc_par(input logic [DW-1:0] p);
        logic [PW-1:0] r = '0;
        for (int b = 0; b < int'(DW); b++) r[b / CW] = r[b / CW] ^ p[b];
        return r;
    endfunction

    function automatic logic [IW-1:0] good_beat(input logic [DW-1:0] p);
        return {calc_par(p), p};
    endfunction

    function automatic logic [DW-1:0] rand_pl();
        logic [IW-1:0] t;
        for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    task automatic model_reset();
        p_vld = 1'b0; p_data = '0; p_err = '0;
        o_vld = 1'b0; o_err = '0;
        m_dout = '0; m_stky = 1'b0; m_first = '0; m_cnt = '0;
    endtask

    task automatic check_outputs();
        chk("data_out_vld", bus.data_out_vld, o_vld);
        chk("data_out", bus.data_out, m_dout);
        chk("prty_err", bus.prty_err, o_err);
        chk("prty_err_pls", bus.prty_err_pls, o_err != '0);
        chk("prty_err_stky", bus.prty_err_stky, m_stky);
        chk("first_err_cell", bus.first_err_cell, m_first);
        chk("err_cnt", bus.err_cnt, m_cnt);
    endtask

    // One clock: drive inputs, advance model, compare all outputs #1 after the edge.
    // The beat landing on the outputs is the one driven a cycle earlier; the
    // clear driven this cycle is applied before that beat's error.
    task automatic cycle(input logic vld, input logic [IW-1:0] din, input logic clr);
        bus.data_in_vld = vld;
        bus.data_in     = din;
        bus.err_clr     = clr;
        @(posedge clk_sys);
        #1;
        if (clr) begin
            m_stky = 1'b0; m_first = '0; m_cnt = '0;
        end
        o_vld = p_vld;
        o_err = p_vld ? p_err : '0;
        if (p_vld) m_dout = p_data;
        if (o_err != '0) begin
            if (!m_stky) m_first = o_err;
            m_stky = 1'b1;
`ifdef PRTY_CHK_ERR_CNT_EN
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
`endif
        end
        check_outputs();
        p_vld  = vld;
        p_data = din[DW-1:0];
        p_err  = calc_par(din[DW-1:0]) ^ din[IW-1:DW];
    endtask

    logic [IW-1:0]   din;
    logic [CNTW-1:0] exp_cnt;

    initial begin
        bus.data_in_vld = 1'b0;
        bus.data_in     = '0;
        bus.err_clr     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #3 rst_n = 1'b1;
        #1 check_outputs();

        // All-zero beat: appears exactly two edges later, clean.
        cycle(1'b1, '0, 1'b0);
        chk("zero_vld_early", bus.data_out_vld, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("zero_vld", bus.data_out_vld, 1'b1);
        chk("zero_err", bus.prty_err, 9'h000);
        chk("zero_stky", bus.prty_err_stky, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("zero_vld_gone", bus.data_out_vld, 1'b0);

        // Payload bit 40 flipped: cell 1.
        din = '0; din[40] = 1'b1;
        cycle(1'b1, din, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("b40_err", bus.prty_err, 9'h002);
        chk("b40_pls", bus.prty_err_pls, 1'b1);
        chk("b40_stky", bus.prty_err_stky, 1'b1);
        chk("b40_first", bus.first_err_cell, 9'h002);
`ifdef PRTY_CHK_ERR_CNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        chk("b40_cnt", bus.err_cnt, exp_cnt);
        cycle(1'b0, '0, 1'b0);
        chk("b40_pls_one", bus.prty_err_pls, 1'b0);
        chk("b40_stky_hold", bus.prty_err_stky, 1'b1);

        // Short last cell, then a two-cell error; first capture keeps the earlier one.
        cycle(1'b0, '0, 1'b1);
        chk("clr_stky", bus.prty_err_stky, 1'b0);
        din = '0; din[278] = 1'b1;
        cycle(1'b1, din, 1'b0);
        din = '0; din[0] = 1'b1; din[100] = 1'b1;
        cycle(1'b1, din, 1'b0);
        chk("b278_err", bus.prty_err, 9'h100);
        cycle(1'b0, '0, 1'b0);
        chk("b0_100_err", bus.prty_err, 9'h009);
        chk("b0_100_first", bus.first_err_cell, 9'h100);
`ifdef PRTY_CHK_ERR_CNT_EN
        exp_cnt = 16'd2;
`else
        exp_cnt = 16'd0;
`endif
        chk("b0_100_cnt", bus.err_cnt, exp_cnt);

        // Randomized traffic with occasional corruption and clears.
        for (int n = 0; n < 400; n++) begin
            din = good_beat(rand_pl());
            if ($urandom_range(0, 2) == 0) din[$urandom_range(0, IW - 1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) din[$urandom_range(0, IW - 1)] ^= 1'b1;
            cycle($urandom_range(0, 3) != 0, din, $urandom_range(0, 19) == 0);
        end
        cycle(1'b0, '0, 1'b0);

`ifdef PRTY_CHK_ERR_CNT_EN
        // Counter saturation.
        cycle(1'b0, '0, 1'b1);
        din = '0; din[40] = 1'b1;
        for (int n = 0; n < 65540; n++) cycle(1'b1, din, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("sat_cnt", bus.err_cnt, 16'hFFFF);
`endif

        // Clear on the same edge that lands an errored beat: error is kept.
        din = '0; din[40] = 1'b1;
        cycle(1'b1, din, 1'b0);
        cycle(1'b0, '0, 1'b1);
`ifdef PRTY_CHK_ERR_CNT_EN
        exp_cnt = 16'd1;
`else
        exp_cnt = 16'd0;
`endif
        chk("clr_hit_cnt", bus.err_cnt, exp_cnt);
        chk("clr_hit_stky", bus.prty_err_stky, 1'b1);
        chk("clr_hit_first", bus.first_err_cell, 9'h002);

        // Reset with two beats in flight.
        cycle(1'b1, good_beat(rand_pl()), 1'b0);
        din = good_beat(rand_pl()); din[5] ^= 1'b1;
        cycle(1'b1, din, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_vld", bus.data_out_vld, 1'b0);
        chk("rst_dout", bus.data_out, '0);
        chk("rst_err", bus.prty_err, '0);
        chk("rst_pls", bus.prty_err_pls, 1'b0);
        chk("rst_stky", bus.prty_err_stky, 1'b0);
        chk("rst_first", bus.first_err_cell, '0);
        chk("rst_cnt", bus.err_cnt, '0);
        bus.data_in_vld = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #3 rst_n = 1'b1;
        repeat (4) cycle(1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
